tcu_host_sequencer: RTL and testbench



---
 rtl/tcu_host_sequencer_if.sv | 30 +++
 rtl/tcu_host_sequencer.sv | 121 ++++++++++++
 tb/tb_tcu_host_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcu_host_sequencer_if.sv
// Host <-> TCU buffer and upstream/downstream stream bundle for tcu_host_sequencer.
// Handshake rule: a word moves on a rising clk edge where valid and ready are both high; valid never waits on ready.
interface tcu_host_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              valid_data;
  logic [DATA_W-1:0] tcu_abc_input;
  logic              tcu_enable;
  logic              result_valid;
  logic [DATA_W-1:0] tcu_d_output;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  // Sequencer view.
  modport master (
    input  s_valid, s_data, tcu_enable, tcu_d_output, m_ready,
    output s_ready, valid_data, tcu_abc_input, result_valid, m_valid, m_data, m_last
  );

  // Environment view: upstream source, TCU buffer and downstream sink.
  modport slave (
    output s_valid, s_data, tcu_enable, tcu_d_output, m_ready,
    input  s_ready, valid_data, tcu_abc_input, result_valid, m_valid, m_data, m_last
  );
endinterface

// File: rtl/tcu_host_sequencer.sv
// Streams one operand batch into the TCU buffer, waits for enable plus compute latency,
// then drains the result words downstream while stepping the buffer read index.
module tcu_host_sequencer #(
  parameter int DATA_W      = 32,
  parameter int NUM_IN      = 96,
  parameter int NUM_OUT     = 32,
  parameter int COMPUTE_LAT = 8,
  parameter int EN_TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  tcu_host_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            state_dbg
);
  localparam int IN_W    = $clog2(NUM_IN);
  localparam int OUT_W   = $clog2(NUM_OUT);
  localparam int LAT_MAX = (EN_TIMEOUT > COMPUTE_LAT) ? EN_TIMEOUT : COMPUTE_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT_EN = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [IN_W-1:0]     in_cnt;
  logic [OUT_W-1:0]    out_cnt;
  logic [LAT_W-1:0]    lat_cnt;

  logic                s_ready_c, valid_data_c, m_valid_c, m_last_c, result_valid_c;
  logic [DATA_W-1:0]   abc_c, m_data_c;

  logic in_last, out_last, en_timeout, cmp_last;

  assign in_last    = (in_cnt == IN_W'(NUM_IN - 1));
  assign out_last   = (out_cnt == OUT_W'(NUM_OUT - 1));
  assign cmp_last   = (lat_cnt == LAT_W'(COMPUTE_LAT - 1));
  assign en_timeout = (state == WAIT_EN) && !bus.tcu_enable && (lat_cnt == LAT_W'(EN_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.s_valid) state_nxt = LOAD;
      LOAD:    if (valid_data_c && in_last) state_nxt = WAIT_EN;
      WAIT_EN: begin
        if (bus.tcu_enable)  state_nxt = COMPUTE;
        else if (en_timeout) state_nxt = IDLE;
      end
      COMPUTE: if (cmp_last) state_nxt = DRAIN;
      DRAIN:   if (result_valid_c && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stream outputs are pure functions of state and the live handshake inputs.
  always_comb begin
    s_ready_c      = 1'b0;
    valid_data_c   = 1'b0;
    abc_c          = '0;
    m_valid_c      = 1'b0;
    m_data_c       = '0;
    m_last_c       = 1'b0;
    result_valid_c = 1'b0;
    case (state)
      LOAD: begin
        s_ready_c    = 1'b1;
        valid_data_c = bus.s_valid;
        abc_c        = bus.s_data;
      end
      DRAIN: begin
        m_valid_c      = 1'b1;
        m_data_c       = bus.tcu_d_output;
        m_last_c       = out_last;
        result_valid_c = bus.m_ready;
      end
      default: ;
    endcase
  end

  // Counters and flags; lat_cnt is shared by the enable wait and the compute delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      lat_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= result_valid_c && out_last;
      if (en_timeout) err <= 1'b1;
      if (valid_data_c)   in_cnt  <= in_last  ? '0 : in_cnt + IN_W'(1);
      if (result_valid_c) out_cnt <= out_last ? '0 : out_cnt + OUT_W'(1);
      case (state)
        WAIT_EN: lat_cnt <= (bus.tcu_enable || en_timeout) ? '0 : lat_cnt + LAT_W'(1);
        COMPUTE: lat_cnt <= cmp_last ? '0 : lat_cnt + LAT_W'(1);
        default: lat_cnt <= '0;
      endcase
    end
  end

  assign bus.s_ready       = s_ready_c;
  assign bus.valid_data    = valid_data_c;
  assign bus.tcu_abc_input = abc_c;
  assign bus.m_valid       = m_valid_c;
  assign bus.m_data        = m_data_c;
  assign bus.m_last        = m_last_c;
  assign bus.result_valid  = result_valid_c;
  assign busy              = (state != IDLE);
  assign state_dbg         = state;
endmodule

// File: tb/tb_tcu_host_sequencer.sv
// Bench for tcu_host_sequencer: behavioural TCU buffer stub, random batches, expected-result queue.
module tb_tcu_host_sequencer;
  localparam int DW = 32;
  localparam int NI = 96;
  localparam int NO = 32;
  localparam int CL = 8;
  localparam int ET = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, done, err;
  logic [2:0] state_dbg;

  tcu_host_sequencer_if #(.DATA_W(DW)) bus ();

  tcu_host_sequencer #(
    .DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .COMPUTE_LAT(CL), .EN_TIMEOUT(ET)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [DW-1:0] words [NI];
  logic [DW-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // TCU buffer stub: captures shifted words, raises enable a few cycles after a full batch,
  // serves results from a 5-bit read index that only rst clears.
  logic [DW-1:0] sh [NI];
  logic [DW-1:0] res_mem [NO];
  logic [4:0]    rd_idx;
  int  sh_cnt = 0;
  int  batch_id = 0;
  int  dly = 0;
  bit  pend = 0;
  bit  en_allow = 1;

  assign bus.tcu_d_output = res_mem[rd_idx];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_cnt = 0;
      pend = 0;
      rd_idx <= '0;
      bus.tcu_enable <= 1'b0;
    end else begin
      if (bus.result_valid) rd_idx <= rd_idx + 5'd1;
      if (bus.valid_data) begin
        if (sh_cnt == NI) sh_cnt = 0;
        bus.tcu_enable <= 1'b0;
        sh[sh_cnt] = bus.tcu_abc_input;
        sh_cnt++;
        if (sh_cnt == NI) begin
          for (int k = 0; k < NO; k++) res_mem[k] = sh[k] ^ (sh[k+32] + sh[k+64]);
          pend = 1;
          dly = $urandom_range(0, 3);
          batch_id++;
        end
      end else if (pend) begin
        if (dly == 0) begin
          if (en_allow) bus.tcu_enable <= 1'b1;
          pend = 0;
        end else dly--;
      end
    end
  end

  // Event monitor, sampled mid-cycle.
  int vd_cnt = 0, rv_cnt = 0, done_cnt = 0, bad_cnt = 0;
  int en_cyc = 0, en_batch = 0;
  always @(negedge clk) begin
    if (bus.valid_data) vd_cnt++;
    if (bus.result_valid) rv_cnt++;
    if (done) done_cnt++;
    if ((bus.valid_data && bus.result_valid) || (bus.result_valid && !bus.m_valid) ||
        (bus.valid_data && !bus.s_ready)) bad_cnt++;
    if (bus.tcu_enable && en_batch != batch_id) begin
      en_batch = batch_id;
      en_cyc = cyc;
    end
  end

  task automatic make_batch(input bit seq);
    for (int i = 0; i < NI; i++) words[i] = seq ? DW'(i) : DW'($urandom);
    for (int k = 0; k < NO; k++) exp_q.push_back(words[k] ^ (words[k+32] + words[k+64]));
  endtask

  // Returns at #1 after the edge that accepted word n-1.
  task automatic load_words(input int n, input bit gaps);
    int idx = 0;
    int guard = 0;
    bit ph = 1;
    bit acc;
    while (idx < n && guard < 1000) begin
      bus.s_valid = gaps ? ph : 1'b1;
      ph = !ph;
      bus.s_data = words[idx];
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    tests++;
    if (idx != n) begin
      fails++;
      $display("FAIL load_count: accepted %0d words, required %0d", idx, n);
    end
  endtask

  task automatic drain_batch(input bit stall);
    int guard = 0;
    int got = 0;
    int d = 0;
    bit rdy;
    logic [DW-1:0] e;
    bus.m_ready = 1'b0;
    while (!bus.m_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (!bus.m_valid) begin
      fails++;
      $display("FAIL drain_start: m_valid never rose within %0d cycles", guard);
      exp_q.delete();
      return;
    end
    tests++;
    if (cyc - en_cyc != CL + 1) begin
      fails++;
      $display("FAIL first_result_latency: %0d cycles after enable, required %0d", cyc - en_cyc, CL + 1);
    end
    tests++;
    if (rd_idx !== 5'd0) begin
      fails++;
      $display("FAIL batch_index_align: read index %0d at drain start, required 0", rd_idx);
    end
    while (got < NO && d < 100) begin
      rdy = !(stall && (d == 3 || d == 4 || d == 10));
      bus.m_ready = rdy;
      #1;
      e = exp_q[0];
      tests++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== e || bus.m_last !== ((got == NO - 1) ? 1'b1 : 1'b0) ||
          bus.result_valid !== rdy) begin
        fails++;
        $display("FAIL drain_word%0d: valid=%b data=%h last=%b rv=%b, required valid=1 data=%h last=%b rv=%b",
                 got, bus.m_valid, bus.m_data, bus.m_last, bus.result_valid, e, (got == NO - 1), rdy);
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        got++;
      end
      d++;
      @(negedge clk);
    end
    bus.m_ready = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: done=%b busy=%b after last word, required done=1 busy=0", done, busy);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_width: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    tests++;
    if (bus.s_ready !== 1'b0 || bus.valid_data !== 1'b0 || bus.result_valid !== 1'b0 ||
        bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || bus.tcu_abc_input !== '0 || bus.m_data !== '0) begin
      fails++;
      $display("FAIL %s: rdy=%b vd=%b rv=%b mv=%b ml=%b busy=%b done=%b err=%b abc=%h md=%h, required all 0",
               tag, bus.s_ready, bus.valid_data, bus.result_valid, bus.m_valid, bus.m_last,
               busy, done, err, bus.tcu_abc_input, bus.m_data);
    end
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b1;
    bus.s_data = 32'hdead_beef;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_single();
    int vd0, rv0, dn0;
    make_batch(1);
    vd0 = vd_cnt; rv0 = rv_cnt; dn0 = done_cnt;
    load_words(NI, 0);
    tests++;
    if (vd_cnt - vd0 != NI) begin
      fails++;
      $display("FAIL single_valid_data: %0d pulses, required %0d", vd_cnt - vd0, NI);
    end
    drain_batch(0);
    tests++;
    if (rv_cnt - rv0 != NO || done_cnt - dn0 != 1) begin
      fails++;
      $display("FAIL single_counts: result_valid=%0d done=%0d, required %0d and 1", rv_cnt - rv0, done_cnt - dn0, NO);
    end
  endtask

  task automatic test_gaps();
    int vd0;
    int bad;
    make_batch(0);
    vd0 = vd_cnt;
    load_words(NI, 1);
    tests++;
    if (bus.s_ready !== 1'b0 || busy !== 1'b1 || vd_cnt - vd0 != NI) begin
      fails++;
      $display("FAIL gaps_wait_entry: s_ready=%b busy=%b pulses=%0d, required 0 1 %0d", bus.s_ready, busy, vd_cnt - vd0, NI);
    end
    bad = 0;
    for (int i = 0; i < NI; i++) if (sh[i] !== words[i]) bad++;
    tests++;
    if (bad != 0 || sh_cnt != NI) begin
      fails++;
      $display("FAIL gaps_order: %0d words out of place, buffer holds %0d, required 0 and %0d", bad, sh_cnt, NI);
    end
    drain_batch(0);
  endtask

  task automatic test_backpressure();
    int rv0;
    make_batch(0);
    rv0 = rv_cnt;
    load_words(NI, 0);
    drain_batch(1);
    tests++;
    if (rv_cnt - rv0 != NO) begin
      fails++;
      $display("FAIL stall_count: result_valid=%0d, required %0d", rv_cnt - rv0, NO);
    end
  endtask

  task automatic test_back_to_back();
    int rv0;
    rv0 = rv_cnt;
    for (int b = 0; b < 2; b++) begin
      make_batch(0);
      load_words(NI, 0);
      drain_batch(0);
    end
    tests++;
    if (rv_cnt - rv0 != 2 * NO) begin
      fails++;
      $display("FAIL b2b_count: result_valid=%0d, required %0d", rv_cnt - rv0, 2 * NO);
    end
  endtask

  task automatic test_timeout();
    int rv0;
    en_allow = 0;
    make_batch(0);
    exp_q.delete();
    rv0 = rv_cnt;
    load_words(NI, 0);
    for (int i = 0; i <= ET; i++) begin
      @(negedge clk);
      if (i == ET - 1) begin
        tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL timeout_early: err=%b busy=%b at wait cycle %0d, required 0 1", err, busy, i);
        end
      end
    end
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || rv_cnt != rv0) begin
      fails++;
      $display("FAIL timeout_hit: err=%b busy=%b rv=%0d at wait cycle %0d, required 1 0 0", err, busy, rv_cnt - rv0, ET);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: err=%b, required 1", err);
    end
    en_allow = 1;
  endtask

  task automatic test_reset_mid_load();
    int vd0, rv0;
    make_batch(0);
    exp_q.delete();
    load_words(40, 0);
    bus.s_valid = 1'b1;
    rst = 1'b0;
    #1;
    check_idle_outputs("reset_mid_load");
    @(negedge clk);
    check_idle_outputs("reset_held");
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    vd0 = vd_cnt;
    rv0 = rv_cnt;
    make_batch(0);
    load_words(NI, 0);
    drain_batch(0);
    tests++;
    if (vd_cnt - vd0 != NI || rv_cnt - rv0 != NO) begin
      fails++;
      $display("FAIL post_reset_batch: loaded=%0d read=%0d, required %0d and %0d", vd_cnt - vd0, rv_cnt - rv0, NI, NO);
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_single();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    tests++;
    if (bad_cnt != 0) begin
      fails++;
      $display("FAIL handshake_exclusive: %0d cycles with illegal valid_data/result_valid, required 0", bad_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
